id_ex_operand_stage: RTL and testbench
======================================

ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL have port CLK  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have port RESET  in  1  synchronous, active-low reset, sampled on rising CLK edge.
REQ-003 SHALL have port valid_in  in  1  decode holds a valid instruction.
REQ-004 SHALL have port rs1_addr_in  in  5  decode source register 1 index.
REQ-005 SHALL have port rs2_addr_in  in  5  decode source register 2 index.
REQ-006 SHALL have port rd_addr_in  in  5  decode destination index.
REQ-007 SHALL have port rs1_data_in  in  32  register-file read data 1.
REQ-008 SHALL have port rs2_data_in  in  32  register-file read data 2.
REQ-009 SHALL have port imm_in  in  32  sign-extended immediate.
REQ-010 SHALL have port alu_op_in  in  5  ALU opcode, same 5-bit encoding as the ALU.
REQ-011 SHALL have port use_imm_in  in  1  ALU operand 2 = immediate.
REQ-012 SHALL have port reg_write_in  in  1  instruction writes rd.
REQ-013 SHALL have port mem_read_in  in  1  instruction is a load.
REQ-014 SHALL have port flush  in  1  squash decode instruction (branch taken).
REQ-015 SHALL have ports exm_rd (5), exm_reg_write (1), exm_result (32)  in  EX/MEM forwarding source.
REQ-016 SHALL have ports wb_rd (5), wb_reg_write (1), wb_result (32)  in  MEM/WB forwarding source.
REQ-017 SHALL have port alu_data1  out  32  ALU operand 1.
REQ-018 SHALL have port alu_data2  out  32  ALU operand 2.
REQ-019 SHALL have port alu_opcode  out  5  registered ALU opcode.
REQ-020 SHALL have ports rd_out (5), reg_write_out (1), mem_read_out (1), valid_out (1)  out  registered control for the EX stage.
REQ-021 SHALL have port stall  out  1  load-use hazard; decode/fetch hold.

Function
REQ-022 SHALL register on each CLK edge: rs1/rs2 addr, rs1/rs2 data, imm, alu_op, use_imm, rd, reg_write, mem_read, valid (the stage registers).
REQ-023 SHALL compute stall combinationally = mem_read_out & valid_out & valid_in & rd_out!=0 & (rd_out==rs1_addr_in | (rd_out==rs2_addr_in & !use_imm_in)).
REQ-024 SHALL, when stall=1 and flush=0, load a bubble: every stage register cleared to 0 (decode holds its instruction externally, latency +1 cycle).
REQ-025 SHALL, when flush=1, load a bubble regardless of stall; flush has priority.
REQ-026 SHALL load decode inputs unchanged when stall=0 and flush=0; valid_in=0 loads a bubble.
REQ-027 SHALL select forwarded rs1 combinationally: exm_result if exm_reg_write & exm_rd!=0 & exm_rd==stage rs1; else wb_result if wb_reg_write & wb_rd!=0 & wb_rd==stage rs1; else stage rs1 data.
REQ-028 SHALL select forwarded rs2 by the same rule as REQ-027; EX/MEM priority over MEM/WB.
REQ-029 SHALL drive alu_data1 = forwarded rs1; alu_data2 = stage imm if stage use_imm else forwarded rs2.
REQ-030 SHALL never forward to or stall on register x0.
REQ-031 SHALL drive alu_data1, alu_data2 = 0 while valid_out=0, independent of forwarding inputs.
REQ-032 SHALL keep all other outputs combinational from stage registers only; no combinational path from decode inputs except to stall.

Reset
REQ-033 SHALL, when RESET=0 at a CLK edge, clear all stage registers to 0: valid_out=0, reg_write_out=0, mem_read_out=0, rd_out=0, alu_opcode=5'b00000, alu_data1=alu_data2=0; stall=0 follows.
REQ-034 SHALL give reset priority over flush and stall; asserting reset mid-stall discards the bubble and stalled instruction.

Verification
REQ-035 SHALL pass: ADD x3,x1,x2 with rs1=5, rs2=7, no forwarding -> next cycle alu_data1=5, alu_data2=7, alu_opcode=0, rd_out=3, valid_out=1.
REQ-036 SHALL pass: stage rs1=x4, exm_rd=4 result 0x10, wb_rd=4 result 0x20, both write enabled -> alu_data1=0x10; exm_reg_write=0 -> alu_data1=0x20.
REQ-037 SHALL pass: LW x5 in stage, decode ADD x6,x5,x1 -> stall=1 for one cycle, next valid_out=0, then ADD enters with stall=0.
REQ-038 SHALL pass: stall=1 and flush=1 same cycle -> bubble, valid_out=0; exm_rd=0 with exm_result=0xFF -> no forward to x0 operands.
REQ-039 SHALL pass: RESET=0 for one edge mid-stall with valid instruction in stage -> all outputs 0, stall=0 next cycle.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: latches the decoded instruction, resolves operands
// through EX/MEM and MEM/WB bypass, and raises stall on a load-use hazard.
module id_ex_operand_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_in,
  input  logic [4:0]  rs1_addr_in,
  input  logic [4:0]  rs2_addr_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  alu_op_in,
  input  logic        use_imm_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        flush,
  input  logic [4:0]  exm_rd,
  input  logic        exm_reg_write,
  input  logic [31:0] exm_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_result,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        valid_out,
  output logic        stall
);

  logic [4:0]  r_rs1_addr, r_rs2_addr, r_rd, r_alu_op;
  logic [31:0] r_rs1_data, r_rs2_data, r_imm;
  logic        r_use_imm, r_reg_write, r_mem_read, r_valid;

  logic        w_stall, w_bubble;
  logic [31:0] w_fwd1, w_fwd2;

  // Load-use hazard: a load in EX whose rd is read by the decode instruction.
  // rd==0 never stalls; rs2 only counts when it is actually used as operand.
  always_comb begin
    w_stall = r_mem_read & r_valid & valid_in & (r_rd != 5'd0) &
              ((r_rd == rs1_addr_in) | ((r_rd == rs2_addr_in) & ~use_imm_in));
    w_bubble = flush | w_stall | ~valid_in;
  end

  // Stage registers: reset wins, then any bubble source clears everything.
  always_ff @(posedge CLK) begin
    if (!RESET || w_bubble) begin
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd        <= '0;
      r_alu_op    <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_rs1_addr  <= rs1_addr_in;
      r_rs2_addr  <= rs2_addr_in;
      r_rd        <= rd_addr_in;
      r_alu_op    <= alu_op_in;
      r_rs1_data  <= rs1_data_in;
      r_rs2_data  <= rs2_data_in;
      r_imm       <= imm_in;
      r_use_imm   <= use_imm_in;
      r_reg_write <= reg_write_in;
      r_mem_read  <= mem_read_in;
      r_valid     <= 1'b1;
    end
  end

  // Bypass select: EX/MEM is younger so it beats MEM/WB; x0 never bypasses.
  always_comb begin
    w_fwd1 = r_rs1_data;
    if (exm_reg_write && exm_rd != 5'd0 && exm_rd == r_rs1_addr)
      w_fwd1 = exm_result;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == r_rs1_addr)
      w_fwd1 = wb_result;

    w_fwd2 = r_rs2_data;
    if (exm_reg_write && exm_rd != 5'd0 && exm_rd == r_rs2_addr)
      w_fwd2 = exm_result;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == r_rs2_addr)
      w_fwd2 = wb_result;
  end

  // Operands are forced to zero for a bubble so bypass inputs cannot leak in.
  always_comb begin
    alu_data1 = r_valid ? w_fwd1 : 32'd0;
    alu_data2 = r_valid ? (r_use_imm ? r_imm : w_fwd2) : 32'd0;
  end

  assign alu_opcode    = r_alu_op;
  assign rd_out        = r_rd;
  assign reg_write_out = r_reg_write;
  assign mem_read_out  = r_mem_read;
  assign valid_out     = r_valid;
  assign stall         = w_stall;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, hazard sequences,
// and a randomized run against an instruction-level reference model.
module tb_id_ex_operand_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        valid_in;
  logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in, alu_op_in;
  logic [31:0] rs1_data_in, rs2_data_in, imm_in;
  logic        use_imm_in, reg_write_in, mem_read_in, flush;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_reg_write, wb_reg_write;
  logic [31:0] exm_result, wb_result;
  logic [31:0] alu_data1, alu_data2;
  logic [4:0]  alu_opcode, rd_out;
  logic        reg_write_out, mem_read_out, valid_out, stall;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_operand_stage dut (
    .CLK(CLK), .RESET(RESET), .valid_in(valid_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
    .alu_op_in(alu_op_in), .use_imm_in(use_imm_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .flush(flush),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_opcode(alu_opcode),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .valid_out(valid_out), .stall(stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] op, input logic ui,
                       input logic rw, input logic mr);
    valid_in = v; rs1_addr_in = a1; rs2_addr_in = a2; rd_addr_in = rd;
    rs1_data_in = d1; rs2_data_in = d2; imm_in = imm; alu_op_in = op;
    use_imm_in = ui; reg_write_in = rw; mem_read_in = mr;
  endtask

  task automatic fwd(input logic [4:0] erd, input logic ewr, input logic [31:0] eres,
                     input logic [4:0] wrd, input logic wwr, input logic [31:0] wres);
    exm_rd = erd; exm_reg_write = ewr; exm_result = eres;
    wb_rd = wrd; wb_reg_write = wwr; wb_result = wres;
  endtask

  // Empty the stage with one idle decode cycle.
  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 0;
    @(posedge CLK); #1;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  a1, a2, rd, op;
    logic [31:0] d1, d2, imm;
    logic        ui, rw, mr, v, fl;
    logic [4:0]  erd; logic ewr; logic [31:0] eres;
    logic [4:0]  wrd; logic wwr; logic [31:0] wres;
    logic [31:0] x1, x2; logic [4:0] xop, xrd; logic xv;
  } vec_t;

  vec_t vt[9];

  // Instruction-level reference: the instruction currently held in EX.
  typedef struct {
    logic        v;
    logic [4:0]  a1, a2, rd, op;
    logic [31:0] d1, d2, imm;
    logic        ui, rw, mr;
  } instr_t;

  instr_t ex;

  function automatic logic [31:0] bypass(input logic [4:0] a, input logic [31:0] d);
    if (exm_reg_write && exm_rd != 0 && exm_rd == a) return exm_result;
    if (wb_reg_write && wb_rd != 0 && wb_rd == a) return wb_result;
    return d;
  endfunction

  function automatic logic hazard();
    if (!(ex.v && ex.mr && valid_in && ex.rd != 0)) return 1'b0;
    return (ex.rd == rs1_addr_in) || (ex.rd == rs2_addr_in && !use_imm_in);
  endfunction

  initial begin
    RESET = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd(0, 0, 0, 0, 0, 0);

    // Reset state, with a valid instruction presented so reset has work to do
    drive(1, 1, 2, 3, 32'h11, 32'h22, 32'h33, 5'd4, 0, 1, 1);
    fwd(1, 1, 32'hDEAD, 2, 1, 32'hBEEF);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_op", alu_opcode, 0);
    chk("rst_rw_mr", {reg_write_out, mem_read_out}, 0);
    chk("rst_d1", alu_data1, 0);
    chk("rst_d2", alu_data2, 0);
    chk("rst_stall", stall, 0);
    RESET = 1;
    fwd(0, 0, 0, 0, 0, 0);

    //        name        a1 a2 rd op d1          d2     imm           ui rw mr v fl  erd ewr eres        wrd wwr wres        x1          x2           xop xrd xv
    vt[0] = '{"add",      1, 2, 3, 0, 5,          7,     0,            0, 1, 0, 1, 0,  0, 0, 0,           0, 0, 0,           5,          7,           0,  3,  1};
    vt[1] = '{"fwd_exm",  4, 2, 8, 1, 32'h1,      9,     0,            0, 1, 0, 1, 0,  4, 1, 32'h10,      4, 1, 32'h20,      32'h10,     9,           1,  8,  1};
    vt[2] = '{"fwd_wb",   4, 2, 8, 1, 32'h1,      9,     0,            0, 1, 0, 1, 0,  4, 0, 32'h10,      4, 1, 32'h20,      32'h20,     9,           1,  8,  1};
    vt[3] = '{"imm",      1, 4, 9, 2, 32'h11,     3,     32'hFFFFFFF0, 1, 1, 0, 1, 0,  4, 1, 32'h44,      0, 0, 0,           32'h11,     32'hFFFFFFF0, 2, 9,  1};
    vt[4] = '{"wb_rs2",   1, 6, 2, 3, 32'h5,      1,     0,            0, 1, 0, 1, 0,  7, 1, 32'h77,      6, 1, 32'hABC,     32'h5,      32'hABC,     3,  2,  1};
    vt[5] = '{"x0",       0, 0, 1, 4, 32'h55,     32'h66, 0,           0, 1, 0, 1, 0,  0, 1, 32'hFF,      0, 1, 32'hEE,      32'h55,     32'h66,      4,  1,  1};
    vt[6] = '{"flush",    5, 5, 3, 7, 32'h12,     32'h34, 0,           0, 1, 0, 1, 1,  5, 1, 32'h77,      0, 0, 0,           0,          0,           0,  0,  0};
    vt[7] = '{"invalid",  5, 5, 3, 7, 32'h12,     32'h34, 0,           0, 1, 0, 0, 0,  5, 1, 32'h77,      5, 1, 32'h88,      0,          0,           0,  0,  0};
    vt[8] = '{"same_src", 9, 9, 10, 5, 32'h1,     32'h2, 0,            0, 1, 0, 1, 0,  9, 1, 32'h99,      9, 1, 32'h1234,    32'h99,     32'h99,      5,  10, 1};

    for (int i = 0; i < 9; i++) begin
      idle_cycle();
      drive(vt[i].v, vt[i].a1, vt[i].a2, vt[i].rd, vt[i].d1, vt[i].d2, vt[i].imm,
            vt[i].op, vt[i].ui, vt[i].rw, vt[i].mr);
      flush = vt[i].fl;
      @(posedge CLK); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      flush = 0;
      fwd(vt[i].erd, vt[i].ewr, vt[i].eres, vt[i].wrd, vt[i].wwr, vt[i].wres);
      #1;
      chk({vt[i].name, "_d1"}, alu_data1, vt[i].x1);
      chk({vt[i].name, "_d2"}, alu_data2, vt[i].x2);
      chk({vt[i].name, "_op"}, alu_opcode, vt[i].xop);
      chk({vt[i].name, "_rd"}, rd_out, vt[i].xrd);
      chk({vt[i].name, "_vld"}, valid_out, vt[i].xv);
      fwd(0, 0, 0, 0, 0, 0);
    end

    // Load-use: LW x5 then ADD x6,x5,x1
    idle_cycle();
    drive(1, 1, 0, 5, 32'h100, 0, 32'h4, 0, 1, 1, 1);
    @(posedge CLK); #1;
    drive(1, 5, 1, 6, 32'h0, 32'h3, 0, 0, 0, 1, 0);
    #1;
    chk("lu_stall", stall, 1);
    @(posedge CLK); #1;
    chk("lu_bubble_vld", valid_out, 0);
    chk("lu_bubble_stall", stall, 0);
    @(posedge CLK); #1;
    chk("lu_add_vld", valid_out, 1);
    chk("lu_add_rd", rd_out, 6);
    chk("lu_add_stall", stall, 0);

    // Load-use via rs2 is ignored when rs2 is not an operand
    idle_cycle();
    drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 1);
    @(posedge CLK); #1;
    drive(1, 2, 5, 6, 0, 0, 32'h8, 0, 1, 1, 0);
    #1;
    chk("lu_imm_nostall", stall, 0);
    drive(1, 2, 5, 6, 0, 0, 32'h8, 0, 0, 1, 0);
    #1;
    chk("lu_rs2_stall", stall, 1);

    // Stall and flush together -> bubble
    idle_cycle();
    drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 1);
    @(posedge CLK); #1;
    drive(1, 5, 1, 6, 0, 0, 0, 0, 0, 1, 0);
    flush = 1;
    #1;
    chk("sf_stall", stall, 1);
    @(posedge CLK); #1;
    flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sf_vld", valid_out, 0);

    // Reset mid-stall
    idle_cycle();
    drive(1, 1, 0, 5, 32'h9, 0, 0, 5'd3, 0, 1, 1);
    @(posedge CLK); #1;
    drive(1, 5, 1, 6, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("rs_pre_stall", stall, 1);
    RESET = 0;
    @(posedge CLK); #1;
    RESET = 1;
    chk("rs_vld", valid_out, 0);
    chk("rs_rd", rd_out, 0);
    chk("rs_ctl", {reg_write_out, mem_read_out, alu_opcode}, 0);
    chk("rs_d", alu_data1 | alu_data2, 0);
    chk("rs_stall", stall, 0);

    // Randomized run against the instruction-level model
    idle_cycle();
    ex = '{default: '0};
    for (int n = 0; n < 3000; n++) begin
      logic exp_stall;
      logic [31:0] e1, e2;
      RESET = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 5'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 4) < 2);
      fwd(5'($urandom_range(0, 3)), 1'($urandom), $urandom,
          5'($urandom_range(0, 3)), 1'($urandom), $urandom);
      @(negedge CLK);
      exp_stall = hazard();
      e1 = ex.v ? bypass(ex.a1, ex.d1) : 32'd0;
      e2 = !ex.v ? 32'd0 : (ex.ui ? ex.imm : bypass(ex.a2, ex.d2));
      chk("r_stall", stall, exp_stall);
      chk("r_d1", alu_data1, e1);
      chk("r_d2", alu_data2, e2);
      chk("r_ctl", {valid_out, reg_write_out, mem_read_out, rd_out, alu_opcode},
          {ex.v, ex.v & ex.rw, ex.v & ex.mr, ex.v ? ex.rd : 5'd0, ex.v ? ex.op : 5'd0});
      @(posedge CLK);
      if (!RESET || flush || exp_stall || !valid_in)
        ex = '{default: '0};
      else
        ex = '{v: 1'b1, a1: rs1_addr_in, a2: rs2_addr_in, rd: rd_addr_in, op: alu_op_in,
               d1: rs1_data_in, d2: rs2_data_in, imm: imm_in,
               ui: use_imm_in, rw: reg_write_in, mr: mem_read_in};
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
